// File: rtl/fetch_stage_if.sv
// -----------------------------------------------------------------------------
// fetch_stage_if
// Instruction-memory fetch handshake between the fetch stage and imem.
//   imem_req   : fetch request (driven by the fetch stage)
//   imem_addr  : fetch address, equal to the current PC
//   imem_ready : instruction data valid this cycle (driven by memory)
//   imem_rdata : instruction word (driven by memory)
// Modports: master = fetch stage side, slave = memory side.
// -----------------------------------------------------------------------------
interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch stage: owns the PC and the IF/ID pipeline register, fetches
// over a ready handshake, honours hazard-unit stalls (buffering an instruction
// that returns while stalled) and branch/jump flushes (redirect + bubble).
// Keeps saturating stall/flush counters for performance debug.
//
// Ports:
//   clk, rst_n          : clock (rising edge), async active-low reset
//   pc_write            : 0 = hold PC (hazard unit)
//   if_id_write         : 0 = hold IF/ID (hazard unit); either low = full stall
//   flush, redirect_pc  : taken branch/jump from ID and its target
//   imem                : fetch handshake (master side)
//   if_id_pc/inst/valid : IF/ID pipeline register
//   stall_cnt           : cycles with stall asserted and no flush
//   flush_cnt           : flush events
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pc_write,
  input  logic             if_id_write,
  input  logic             flush,
  input  logic [31:0]      redirect_pc,
  fetch_stage_if.master    imem,
  output logic [31:0]      if_id_pc,
  output logic [31:0]      if_id_inst,
  output logic             if_id_valid,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    BUFFER = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        buf_q, buf_d;
  logic [31:0]        if_id_pc_q, if_id_pc_d;
  logic [31:0]        if_id_inst_q, if_id_inst_d;
  logic               if_id_valid_q, if_id_valid_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic               stall_s;

  // Saturating increment: sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      return v;
    end else begin
      return v + CNT_W'(1);
    end
  endfunction

  // Either hazard enable low is treated as a full stall.
  assign stall_s = !pc_write || !if_id_write;

  // Request is a pure decode of the registered state; address is the PC flop.
  assign imem.imem_req  = (state_q == FETCH);
  assign imem.imem_addr = pc_q;

  assign if_id_pc    = if_id_pc_q;
  assign if_id_inst  = if_id_inst_q;
  assign if_id_valid = if_id_valid_q;
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;

  // Next-state, PC, buffer and IF/ID update; priority flush > stall > normal.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    buf_d         = buf_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_inst_d  = if_id_inst_q;
    if_id_valid_d = if_id_valid_q;

    if (flush) begin
      // Redirect and inject a bubble; a same-cycle imem_ready and any
      // buffered word are dropped.
      pc_d          = redirect_pc;
      if_id_pc_d    = 32'h0000_0000;
      if_id_inst_d  = NOP_INST;
      if_id_valid_d = 1'b0;
      state_d       = FETCH;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = FETCH;
        end
        FETCH: begin
          if (imem.imem_ready) begin
            if (stall_s) begin
              // Capture the returning word so it is not lost while stalled.
              buf_d   = imem.imem_rdata;
              state_d = BUFFER;
            end else begin
              if_id_pc_d    = pc_q;
              if_id_inst_d  = imem.imem_rdata;
              if_id_valid_d = 1'b1;
              pc_d          = pc_q + 32'd4;
            end
          end else begin
            if (stall_s) begin
              state_d = FETCH;
            end else begin
              // Memory wait state: pass a bubble downstream, keep the address.
              if_id_pc_d    = 32'h0000_0000;
              if_id_inst_d  = NOP_INST;
              if_id_valid_d = 1'b0;
            end
          end
        end
        BUFFER: begin
          if (stall_s) begin
            state_d = BUFFER;
          end else begin
            if_id_pc_d    = pc_q;
            if_id_inst_d  = buf_q;
            if_id_valid_d = 1'b1;
            pc_d          = pc_q + 32'd4;
            state_d       = FETCH;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Performance counters: stall cycles exclude flush cycles.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (flush) begin
      flush_cnt_d = sat_inc(flush_cnt_q);
    end else if (stall_s) begin
      stall_cnt_d = sat_inc(stall_cnt_q);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // State, PC, buffer, IF/ID and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      buf_q         <= 32'h0000_0000;
      if_id_pc_q    <= 32'h0000_0000;
      if_id_inst_q  <= NOP_INST;
      if_id_valid_q <= 1'b0;
      stall_cnt_q   <= '0;
      flush_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      buf_q         <= buf_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_inst_q  <= if_id_inst_d;
      if_id_valid_q <= if_id_valid_d;
      stall_cnt_q   <= stall_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
// Self-checking bench for fetch_stage. dut_a (default parameters) runs a
// per-cycle vector table whose expected outputs are queued when each row is
// driven and compared after the clock edge; dut_b (RESET_PC near the top of
// the address space, 4-bit counters) covers PC wrap and counter saturation.
// Memory model: imem_rdata = imem_addr + 0x100, ready driven by the bench.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- DUT A ----------------
  logic        rst_n_a, pw_a, iw_a, fl_a, rdy_a;
  logic [31:0] rpc_a;
  logic [31:0] ipc_a, iinst_a;
  logic        ivld_a;
  logic [15:0] scnt_a, fcnt_a;

  fetch_stage_if bus_a ();
  assign bus_a.imem_ready = rdy_a;
  assign bus_a.imem_rdata = bus_a.imem_addr + 32'h0000_0100;

  fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INST(NOP), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n_a), .pc_write(pw_a), .if_id_write(iw_a),
    .flush(fl_a), .redirect_pc(rpc_a), .imem(bus_a),
    .if_id_pc(ipc_a), .if_id_inst(iinst_a), .if_id_valid(ivld_a),
    .stall_cnt(scnt_a), .flush_cnt(fcnt_a)
  );

  // ---------------- DUT B ----------------
  logic        rst_n_b, pw_b, iw_b, fl_b, rdy_b;
  logic [31:0] rpc_b;
  logic [31:0] ipc_b, iinst_b;
  logic        ivld_b;
  logic [3:0]  scnt_b, fcnt_b;

  fetch_stage_if bus_b ();
  assign bus_b.imem_ready = rdy_b;
  assign bus_b.imem_rdata = bus_b.imem_addr + 32'h0000_0100;

  fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .NOP_INST(NOP), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .pc_write(pw_b), .if_id_write(iw_b),
    .flush(fl_b), .redirect_pc(rpc_b), .imem(bus_b),
    .if_id_pc(ipc_b), .if_id_inst(iinst_b), .if_id_valid(ivld_b),
    .stall_cnt(scnt_b), .flush_cnt(fcnt_b)
  );

  // ---------------- vectors and scoreboard ----------------
  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic [31:0] ipc;
    logic [31:0] inst;
    logic        vld;
    logic [15:0] scnt;
    logic [15:0] fcnt;
  } exp_t;

  typedef struct {
    logic        pw;
    logic        iw;
    logic        fl;
    logic [31:0] rpc;
    logic        rdy;
    exp_t        e;
  } vec_t;

  exp_t sb_q[$];
  vec_t tbl[20];

  function automatic vec_t mk(input logic pw, input logic iw, input logic fl,
                              input logic [31:0] rpc, input logic rdy,
                              input logic ereq, input logic [31:0] eaddr,
                              input logic [31:0] eipc, input logic [31:0] einst,
                              input logic evld, input logic [15:0] escnt,
                              input logic [15:0] efcnt);
    vec_t v;
    v.pw = pw; v.iw = iw; v.fl = fl; v.rpc = rpc; v.rdy = rdy;
    v.e.req = ereq; v.e.addr = eaddr; v.e.ipc = eipc; v.e.inst = einst;
    v.e.vld = evld; v.e.scnt = escnt; v.e.fcnt = efcnt;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_reset_a(input string tag);
    check({tag, " req"},   {31'd0, bus_a.imem_req}, 32'd0);
    check({tag, " addr"},  bus_a.imem_addr, 32'h0000_0000);
    check({tag, " ipc"},   ipc_a, 32'h0000_0000);
    check({tag, " inst"},  iinst_a, NOP);
    check({tag, " valid"}, {31'd0, ivld_a}, 32'd0);
    check({tag, " scnt"},  {16'd0, scnt_a}, 32'd0);
    check({tag, " fcnt"},  {16'd0, fcnt_a}, 32'd0);
  endtask

  initial begin
    exp_t e;
    // Rows: pw iw fl rpc rdy | req addr if_id_pc if_id_inst valid stall_cnt flush_cnt
    tbl[0]  = mk(1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 32'h0,   32'h0,   NOP,          1'b0, 16'd0, 16'd0);
    tbl[1]  = mk(1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 32'h4,   32'h0,   32'h100,      1'b1, 16'd0, 16'd0);
    tbl[2]  = mk(1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 32'h4,   32'h0,   NOP,          1'b0, 16'd0, 16'd0);
    tbl[3]  = mk(1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 32'h4,   32'h0,   NOP,          1'b0, 16'd0, 16'd0);
    tbl[4]  = mk(1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 32'h4,   32'h0,   NOP,          1'b0, 16'd0, 16'd0);
    tbl[5]  = mk(1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 32'h8,   32'h4,   32'h104,      1'b1, 16'd0, 16'd0);
    tbl[6]  = mk(1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h8,   32'h4,   32'h104,      1'b1, 16'd1, 16'd0);
    tbl[7]  = mk(1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h8,   32'h4,   32'h104,      1'b1, 16'd2, 16'd0);
    tbl[8]  = mk(1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 32'hC,   32'h8,   32'h108,      1'b1, 16'd2, 16'd0);
    tbl[9]  = mk(1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 32'h10,  32'hC,   32'h10C,      1'b1, 16'd2, 16'd0);
    tbl[10] = mk(1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 32'h10,  32'hC,   32'h10C,      1'b1, 16'd3, 16'd0);
    tbl[11] = mk(1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h10,  32'hC,   32'h10C,      1'b1, 16'd4, 16'd0);
    tbl[12] = mk(1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 32'h14,  32'h10,  32'h110,      1'b1, 16'd4, 16'd0);
    tbl[13] = mk(1'b0, 1'b0, 1'b1, 32'h40,  1'b1, 1'b1, 32'h40,  32'h0,   NOP,          1'b0, 16'd4, 16'd1);
    tbl[14] = mk(1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 32'h44,  32'h40,  32'h140,      1'b1, 16'd4, 16'd1);
    tbl[15] = mk(1'b1, 1'b1, 1'b1, 32'h80,  1'b1, 1'b1, 32'h80,  32'h0,   NOP,          1'b0, 16'd4, 16'd2);
    tbl[16] = mk(1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 32'h84,  32'h80,  32'h180,      1'b1, 16'd4, 16'd2);
    tbl[17] = mk(1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h84,  32'h80,  32'h180,      1'b1, 16'd5, 16'd2);
    tbl[18] = mk(1'b1, 1'b1, 1'b1, 32'h200, 1'b0, 1'b1, 32'h200, 32'h0,   NOP,          1'b0, 16'd5, 16'd3);
    tbl[19] = mk(1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 32'h204, 32'h200, 32'h300,      1'b1, 16'd5, 16'd3);

    rst_n_a = 1'b0; pw_a = 1'b1; iw_a = 1'b1; fl_a = 1'b0; rpc_a = 32'h0; rdy_a = 1'b0;
    rst_n_b = 1'b0; pw_b = 1'b1; iw_b = 1'b1; fl_b = 1'b0; rpc_b = 32'h0; rdy_b = 1'b0;

    // Reset held for three cycles, released between edges.
    repeat (3) @(negedge clk);
    rst_n_a = 1'b1;
    #1;
    check_reset_a("reset");

    // Table-driven run: expectations queued at drive time, popped after edge.
    for (int i = 0; i < 20; i++) begin
      pw_a = tbl[i].pw; iw_a = tbl[i].iw; fl_a = tbl[i].fl;
      rpc_a = tbl[i].rpc; rdy_a = tbl[i].rdy;
      sb_q.push_back(tbl[i].e);
      @(posedge clk);
      #1;
      n_checks++;
      if (sb_q.size() == 0) begin
        n_errors++;
        $display("FAIL row%0d scoreboard: got empty queue expected entry", i);
      end else begin
        n_checks--;
        e = sb_q.pop_front();
        check($sformatf("row%0d req", i),   {31'd0, bus_a.imem_req}, {31'd0, e.req});
        check($sformatf("row%0d addr", i),  bus_a.imem_addr, e.addr);
        check($sformatf("row%0d ipc", i),   ipc_a, e.ipc);
        check($sformatf("row%0d inst", i),  iinst_a, e.inst);
        check($sformatf("row%0d valid", i), {31'd0, ivld_a}, {31'd0, e.vld});
        check($sformatf("row%0d scnt", i),  {16'd0, scnt_a}, {16'd0, e.scnt});
        check($sformatf("row%0d fcnt", i),  {16'd0, fcnt_a}, {16'd0, e.fcnt});
      end
      @(negedge clk);
    end

    // Async reset while an instruction sits in the buffer.
    pw_a = 1'b0; iw_a = 1'b0; fl_a = 1'b0; rdy_a = 1'b1;
    @(posedge clk);
    #1;
    check("buffer entered req", {31'd0, bus_a.imem_req}, 32'd0);
    check("buffer hold inst", iinst_a, 32'h300);
    #2;
    rst_n_a = 1'b0;
    #1;
    check_reset_a("async reset");
    @(negedge clk);
    pw_a = 1'b1; iw_a = 1'b1; rdy_a = 1'b1;
    rst_n_a = 1'b1;
    @(posedge clk);
    #1;
    check("post-reset req", {31'd0, bus_a.imem_req}, 32'd1);
    check("post-reset valid", {31'd0, ivld_a}, 32'd0);
    @(posedge clk);
    #1;
    check("post-reset ipc", ipc_a, 32'h0);
    check("post-reset inst", iinst_a, 32'h100);
    check("post-reset valid2", {31'd0, ivld_a}, 32'd1);

    // DUT B: PC wrap at the top of the address space, then counter saturation.
    @(negedge clk);
    rdy_b = 1'b1;
    rst_n_b = 1'b1;
    #1;
    check("wrap reset addr", bus_b.imem_addr, 32'hFFFF_FFF8);
    @(posedge clk); #1;
    check("wrap c1 req", {31'd0, bus_b.imem_req}, 32'd1);
    check("wrap c1 addr", bus_b.imem_addr, 32'hFFFF_FFF8);
    @(posedge clk); #1;
    check("wrap c2 addr", bus_b.imem_addr, 32'hFFFF_FFFC);
    check("wrap c2 ipc", ipc_b, 32'hFFFF_FFF8);
    check("wrap c2 inst", iinst_b, 32'h0000_00F8);
    @(posedge clk); #1;
    check("wrap c3 addr", bus_b.imem_addr, 32'h0000_0000);
    check("wrap c3 ipc", ipc_b, 32'hFFFF_FFFC);
    @(posedge clk); #1;
    check("wrap c4 ipc", ipc_b, 32'h0000_0000);
    check("wrap c4 inst", iinst_b, 32'h0000_0100);
    @(negedge clk);
    pw_b = 1'b0; iw_b = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("sat stall 10", {28'd0, scnt_b}, 32'd10);
    repeat (10) @(posedge clk);
    #1;
    check("sat stall 20", {28'd0, scnt_b}, 32'd15);
    check("sat flush", {28'd0, fcnt_b}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 5-stage pipeline: owns the PC register and the IF/ID pipeline register, and fetches from instruction memory over a ready-handshake interface. It is the consumer of the stall requests issued by the hazard detection unit. It also consumes branch/jump flushes resolved in ID. On a stall it holds PC and IF/ID, buffering any instruction that returns while stalled. On a flush it redirects and injects a bubble. It also keeps saturating stall and flush counters for performance debug.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- NOP_INST, 32'h0000_0013, instruction word placed in IF/ID for a bubble
- CNT_W, 16, width of performance counters
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  reset; asynchronous, active-low
- pc_write  in  1  from hazard unit; 0 = hold PC
- if_id_write  in  1  from hazard unit; 0 = hold IF/ID
- flush  in  1  branch/jump taken in ID this cycle
- redirect_pc  in  32  target PC, valid when flush=1
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address (= current PC)
- imem_ready  in  1  instruction data valid this cycle
- imem_rdata  in  32  instruction word
- if_id_pc  out  32  PC of instruction in IF/ID
- if_id_inst  out  32  instruction in IF/ID
- if_id_valid  out  1  IF/ID holds a real instruction
- stall_cnt  out  CNT_W  cycles with stall asserted
- flush_cnt  out  CNT_W  flush events

## Operation
- stall = !pc_write | !if_id_write. The hazard unit drives both together, but either low is treated as a full stall.
- States: IDLE, FETCH, BUFFER. Reset enters IDLE, and IDLE goes to FETCH unconditionally on the next cycle.
- imem_req = (state == FETCH), registered state decode. imem_addr = pc.
- Priority each cycle: flush > stall > normal.
- Flush (any state):
  - pc <= redirect_pc.
  - IF/ID <= {pc: 0, inst: NOP_INST, valid: 0}.
  - Buffer discarded; state <= FETCH.
  - An imem_ready arriving in the same cycle is dropped.
- FETCH, imem_ready=1, no stall: IF/ID <= {pc, imem_rdata, 1}; pc <= pc+4; stay FETCH.
- FETCH, imem_ready=1, stall: buffer <= imem_rdata; state <= BUFFER; pc and IF/ID hold.
- FETCH, imem_ready=0, no stall: IF/ID <= bubble (NOP_INST, valid 0); pc holds.
- FETCH, imem_ready=0, stall: everything holds.
- BUFFER, stall: hold; imem_req=0.
- BUFFER, no stall: IF/ID <= {pc, buffer, 1}; pc <= pc+4; state <= FETCH.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 wraps to 0. No alignment checking.
- imem_addr stays stable while imem_req=1 and imem_ready=0, except on flush. On flush the address changes, and memory must treat the new address as a new request.
- Counters:
  - stall_cnt increments on every cycle where stall=1 and flush=0.
  - flush_cnt increments on every cycle where flush=1.
  - Both saturate at all-ones. Neither is cleared except by reset.

## Timing
- Reset values: pc = RESET_PC, imem_req = 0, imem_addr = RESET_PC, if_id_pc = 0, if_id_inst = NOP_INST, if_id_valid = 0, stall_cnt = 0, flush_cnt = 0, state = IDLE.
- Assertion of rst_n low mid-operation takes effect immediately, with no clock needed. Any buffered instruction is lost.
- First imem_req is high in the 2nd cycle after rst_n rises.
- With imem_ready tied high: an instruction addressed in cycle N appears on if_id_* after the edge ending cycle N. Throughput is one instruction per cycle.
- A stall in cycle N freezes if_id_* at the edge ending N. Release in cycle M lets the held or buffered instruction advance at the edge ending M, with no instruction lost or duplicated.
- Flush in cycle N: imem_addr = redirect_pc and if_id_valid = 0 from cycle N+1. The redirected instruction reaches IF/ID no earlier than the end of N+1.
- Flush and stall in the same cycle: flush wins, and stall_cnt does not increment.

## Test plan
- Sequential fetch: rst_n low 3 cycles then high, imem_ready=1, rdata = addr+0x100 → IF/ID delivers pc 0,4,8 with inst 0x100,0x104,0x108. if_id_valid is 1 from the 3rd cycle after reset release.
- Stall with buffering: stall 2 cycles while ready=1 for pc 8 → state BUFFER and imem_req=0. On release, IF/ID gets {8, 0x108, 1} and the next address is 12. stall_cnt = 2.
- Wait states: imem_ready low 3 cycles at pc 4 → imem_addr held at 4, three bubbles (NOP_INST, valid 0), then {4, 0x104, 1}.
- Flush priority: flush=1, redirect_pc = 0x40, with stall=1 and imem_ready=1 in the same cycle → next cycle imem_addr = 0x40 and if_id_valid = 0. flush_cnt = 1 and stall_cnt unchanged.
- Wrap and saturation: RESET_PC = 32'hFFFF_FFF8 → addresses FFFF_FFF8, FFFF_FFFC, 0. With CNT_W = 4, a 20-cycle stall leaves stall_cnt = 15.
- Async reset mid-BUFFER: drop rst_n between clock edges → all outputs take their reset values immediately, and the buffer content never appears in IF/ID.
